// File: rtl/reg_wr_pkg.sv
// Shared state encoding, grant encoding and address constants for the register-bank write arbiter.
package reg_wr_pkg;

  localparam int unsigned DW_DEF    = 8;
  localparam int unsigned AW_DEF    = 2;

  localparam int unsigned ADDR_NONE = 0;
  localparam int unsigned ADDR_REG1 = 1;
  localparam int unsigned ADDR_REG2 = 2;
  localparam int unsigned ADDR_REG3 = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_ACK   = 2'b10
  } state_t;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_t;

  // B wins when it is alone, or on contention when rotation is enabled and A was served last.
  function automatic logic pick_b(input logic req_a, input logic req_b,
                                  input grant_t last, input logic rr_en);
    return req_b & (~req_a | (rr_en & (last == GRANT_A)));
  endfunction

endpackage

// File: rtl/reg_wr_addr_dec.sv
// Combinational decode of a bank address to one-hot chip selects plus a valid flag.
module reg_wr_addr_dec
  import reg_wr_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic [AW-1:0] i_addr,
  output logic [2:0]    o_cs,
  output logic          o_valid
);

  // Address 0 (and anything unmapped) selects nothing.
  always_comb begin
    o_cs    = 3'b000;
    o_valid = 1'b0;
    case (i_addr)
      AW'(ADDR_REG1): begin o_cs = 3'b001; o_valid = 1'b1; end
      AW'(ADDR_REG2): begin o_cs = 3'b010; o_valid = 1'b1; end
      AW'(ADDR_REG3): begin o_cs = 3'b100; o_valid = 1'b1; end
      default:        begin o_cs = 3'b000; o_valid = 1'b0; end
    endcase
  end

endmodule

// File: rtl/reg_wr_arbiter.sv
// Two-requester arbiter onto the register bank write port (IDLE -> WRITE -> ACK).
// Define REG_WR_ARB_RR_EN for round-robin contention; default is fixed priority to A.
module reg_wr_arbiter
  import reg_wr_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] data_a,
  input  logic          req_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] data_b,
  output logic          ack_a,
  output logic          ack_b,
  output logic          err,
  output logic          my_wr,
  output logic          CS_Reg1,
  output logic          CS_Reg2,
  output logic          CS_Reg3,
  output logic [DW-1:0] Data
);

`ifdef REG_WR_ARB_RR_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  state_t        r_state,      w_state_nxt;
  grant_t        r_grant,      w_grant_nxt;
  grant_t        r_last_grant, w_last_grant_nxt;
  logic          r_err_pend,   w_err_pend_nxt;
  logic          r_my_wr,      w_my_wr_nxt;
  logic [2:0]    r_cs,         w_cs_nxt;
  logic [DW-1:0] r_data,       w_data_nxt;
  logic          r_ack_a,      w_ack_a_nxt;
  logic          r_ack_b,      w_ack_b_nxt;
  logic          r_err,        w_err_nxt;

  logic          w_pick_b;
  logic [AW-1:0] w_sel_addr;
  logic [2:0]    w_dec_cs;
  logic          w_dec_valid;

  assign w_pick_b   = pick_b(req_a, req_b, r_last_grant, RR_EN);
  assign w_sel_addr = w_pick_b ? addr_b : addr_a;

  reg_wr_addr_dec #(.AW(AW)) u_dec (
    .i_addr  (w_sel_addr),
    .o_cs    (w_dec_cs),
    .o_valid (w_dec_valid)
  );

  // Next-state and next-output logic; strobes and acks default low so each lasts one cycle.
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    w_err_pend_nxt   = r_err_pend;
    w_my_wr_nxt      = 1'b0;
    w_cs_nxt         = 3'b000;
    w_data_nxt       = r_data;
    w_ack_a_nxt      = 1'b0;
    w_ack_b_nxt      = 1'b0;
    w_err_nxt        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_a || req_b) begin
          w_grant_nxt    = w_pick_b ? GRANT_B : GRANT_A;
          w_data_nxt     = w_pick_b ? data_b : data_a;
          w_my_wr_nxt    = w_dec_valid;
          w_cs_nxt       = w_dec_cs;
          w_err_pend_nxt = ~w_dec_valid;
          w_state_nxt    = ST_WRITE;
        end else begin
          w_state_nxt    = ST_IDLE;
        end
      end
      ST_WRITE: begin
        w_ack_a_nxt = (r_grant == GRANT_A);
        w_ack_b_nxt = (r_grant == GRANT_B);
        w_err_nxt   = r_err_pend;
        w_state_nxt = ST_ACK;
      end
      ST_ACK: begin
        w_last_grant_nxt = r_grant;
        w_err_pend_nxt   = 1'b0;
        w_state_nxt      = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers; last_grant resets to B so A wins the first contention.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= GRANT_A;
      r_last_grant <= GRANT_B;
      r_err_pend   <= 1'b0;
      r_my_wr      <= 1'b0;
      r_cs         <= 3'b000;
      r_data       <= '0;
      r_ack_a      <= 1'b0;
      r_ack_b      <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_err_pend   <= w_err_pend_nxt;
      r_my_wr      <= w_my_wr_nxt;
      r_cs         <= w_cs_nxt;
      r_data       <= w_data_nxt;
      r_ack_a      <= w_ack_a_nxt;
      r_ack_b      <= w_ack_b_nxt;
      r_err        <= w_err_nxt;
    end
  end

  assign my_wr   = r_my_wr;
  assign CS_Reg1 = r_cs[0];
  assign CS_Reg2 = r_cs[1];
  assign CS_Reg3 = r_cs[2];
  assign Data    = r_data;
  assign ack_a   = r_ack_a;
  assign ack_b   = r_ack_b;
  assign err     = r_err;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Table-driven bench for reg_wr_arbiter; expected outputs are given per cycle after each rising edge.
module tb_reg_wr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, req_b;
  logic [1:0] addr_a, addr_b;
  logic [7:0] data_a, data_b;
  logic       ack_a, ack_b, err, my_wr, CS_Reg1, CS_Reg2, CS_Reg3;
  logic [7:0] Data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_wr_arbiter #(.DW(8), .AW(2)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .addr_a(addr_a), .data_a(data_a),
    .req_b(req_b), .addr_b(addr_b), .data_b(data_b),
    .ack_a(ack_a), .ack_b(ack_b), .err(err), .my_wr(my_wr),
    .CS_Reg1(CS_Reg1), .CS_Reg2(CS_Reg2), .CS_Reg3(CS_Reg3), .Data(Data)
  );

  typedef struct packed {
    logic       rst;
    logic       ra;
    logic [1:0] aa;
    logic [7:0] da;
    logic       rb;
    logic [1:0] ab;
    logic [7:0] db;
    logic       wr;
    logic [2:0] cs;
    logic [7:0] dat;
    logic       aka;
    logic       akb;
    logic       er;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic ra, logic [1:0] aa, logic [7:0] da,
                              logic rb, logic [1:0] ab, logic [7:0] db,
                              logic wr, logic [2:0] cs, logic [7:0] dat,
                              logic aka, logic akb, logic er);
    vec_t v;
    v.rst = r; v.ra = ra; v.aa = aa; v.da = da; v.rb = rb; v.ab = ab; v.db = db;
    v.wr = wr; v.cs = cs; v.dat = dat; v.aka = aka; v.akb = akb; v.er = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic wr, input logic [2:0] cs,
                         input logic [7:0] d, input logic aka, input logic akb, input logic er);
    logic [2:0] cs_act;
    cs_act = {CS_Reg3, CS_Reg2, CS_Reg1};
    chk({tag, ".my_wr"}, 32'(my_wr), 32'(wr));
    chk({tag, ".cs"},    32'(cs_act), 32'(cs));
    chk({tag, ".data"},  32'(Data), 32'(d));
    chk({tag, ".ack_a"}, 32'(ack_a), 32'(aka));
    chk({tag, ".ack_b"}, 32'(ack_b), 32'(akb));
    chk({tag, ".err"},   32'(err), 32'(er));
    chk({tag, ".cs_onehot0"}, 32'($countones(cs_act) <= 1), 32'(1));
  endtask

  initial begin
    logic       rr;
    logic [2:0] cs_r2;
    logic [7:0] d_r2;
`ifdef REG_WR_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    cs_r2 = rr ? 3'b100 : 3'b001;
    d_r2  = rr ? 8'h33 : 8'h11;

    rst = 1'b0; req_a = 1'b0; req_b = 1'b0;
    addr_a = 2'd0; addr_b = 2'd0; data_a = 8'h00; data_b = 8'h00;

    // reset
    tbl.push_back(mk(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0));
    // single A write to Reg2
    tbl.push_back(mk(1'b1, 1'b1, 2'd2, 8'h5A, 1'b0, 2'd0, 8'h00, 1'b1, 3'b010, 8'h5A, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 2'd2, 8'h5A, 1'b0, 2'd0, 8'h00, 1'b0, 3'b000, 8'h5A, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 2'd2, 8'h5A, 1'b0, 2'd0, 8'h00, 1'b0, 3'b000, 8'h5A, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 3'b000, 8'h5A, 1'b0, 1'b0, 1'b0));
    // B to invalid address 0
    tbl.push_back(mk(1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 8'hFF, 1'b0, 3'b000, 8'hFF, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 8'hFF, 1'b0, 3'b000, 8'hFF, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 8'hFF, 1'b0, 3'b000, 8'hFF, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 3'b000, 8'hFF, 1'b0, 1'b0, 1'b0));
    // contention, both held for three rounds
    tbl.push_back(mk(1'b1, 1'b1, 2'd1, 8'h11, 1'b1, 2'd3, 8'h33, 1'b1, 3'b001, 8'h11, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 2'd1, 8'h11, 1'b1, 2'd3, 8'h33, 1'b0, 3'b000, 8'h11, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 2'd1, 8'h11, 1'b1, 2'd3, 8'h33, 1'b0, 3'b000, 8'h11, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 2'd1, 8'h11, 1'b1, 2'd3, 8'h33, 1'b1, cs_r2,  d_r2,  1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 2'd1, 8'h11, 1'b1, 2'd3, 8'h33, 1'b0, 3'b000, d_r2,  ~rr,  rr,   1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 2'd1, 8'h11, 1'b1, 2'd3, 8'h33, 1'b0, 3'b000, d_r2,  1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 2'd1, 8'h11, 1'b1, 2'd3, 8'h33, 1'b1, 3'b001, 8'h11, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 2'd1, 8'h11, 1'b1, 2'd3, 8'h33, 1'b0, 3'b000, 8'h11, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 2'd1, 8'h11, 1'b1, 2'd3, 8'h33, 1'b0, 3'b000, 8'h11, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 3'b000, 8'h11, 1'b0, 1'b0, 1'b0));
    // back-to-back: A Reg1=A1, then B Reg3=B3 one cycle after ack_a
    tbl.push_back(mk(1'b1, 1'b1, 2'd1, 8'hA1, 1'b0, 2'd0, 8'h00, 1'b1, 3'b001, 8'hA1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 2'd1, 8'hA1, 1'b0, 2'd0, 8'h00, 1'b0, 3'b000, 8'hA1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 2'd1, 8'hA1, 1'b0, 2'd0, 8'h00, 1'b0, 3'b000, 8'hA1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 8'hB3, 1'b1, 3'b100, 8'hB3, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 8'hB3, 1'b0, 3'b000, 8'hB3, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 8'hB3, 1'b0, 3'b000, 8'hB3, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 3'b000, 8'hB3, 1'b0, 1'b0, 1'b0));

    #2;
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst;
      req_a = tbl[i].ra; addr_a = tbl[i].aa; data_a = tbl[i].da;
      req_b = tbl[i].rb; addr_b = tbl[i].ab; data_b = tbl[i].db;
      @(posedge clk); #1;
      chk_all($sformatf("v%0d", i), tbl[i].wr, tbl[i].cs, tbl[i].dat,
              tbl[i].aka, tbl[i].akb, tbl[i].er);
    end

    // reset pulled low during WRITE: strobes clear at once, no ack, full latency on re-request
    req_a = 1'b1; addr_a = 2'd2; data_a = 8'h77;
    @(posedge clk); #1;
    chk_all("rst.write", 1'b1, 3'b010, 8'h77, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk_all("rst.async", 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("rst.held", 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_all("rst.regrant", 1'b1, 3'b010, 8'h77, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("rst.ack", 1'b0, 3'b000, 8'h77, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("rst.ackdone", 1'b0, 3'b000, 8'h77, 1'b0, 1'b0, 1'b0);
    req_a = 1'b0;
    @(posedge clk); #1;
    chk_all("rst.idle", 1'b0, 3'b000, 8'h77, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
